// File: rtl/if_inst_buffer.sv
// Fetch-to-decode decoupling FIFO of {pc, inst} pairs.
// Drops wrong-path fetches on a taken branch and holds the PC register when full.
module if_inst_buffer #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RST_PC_VAL = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fs_valid,
    input  logic [31:0]                fs_pc,
    input  logic [31:0]                fs_inst,
    input  logic                       br_flush,
    input  logic                       ds_allowin,
    output logic                       fs_allowin,
    output logic                       ds_valid,
    output logic [31:0]                ds_pc,
    output logic [31:0]                ds_inst,
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [63:0]   head_ent;
    logic          push;
    logic          pop;

    // Allow-in depends only on registered occupancy, never on ds_allowin.
    assign fs_allowin = (count != CW'(DEPTH));
    assign push       = fs_valid & fs_allowin & ~br_flush & ~rst;
    assign ds_valid   = (count != '0);
    assign pop        = ds_valid & ds_allowin;
    assign buf_count  = count;
    assign head_ent   = mem[head];
    assign ds_pc      = ds_valid ? head_ent[63:32] : RST_PC_VAL;
    assign ds_inst    = ds_valid ? head_ent[31:0]  : 32'h0;

    // Entry storage: write the accepted fetch pair at the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {fs_pc, fs_inst};
        end
    end

    // Pointers and occupancy; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || br_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_inst_buffer.sv
// Self-checking bench for if_inst_buffer (DEPTH=2).
// Scoreboard of expected {pc, inst} pairs against pairs decode consumed.
module tb_if_inst_buffer;

    localparam logic [31:0] BASE = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        br_flush;
    logic        ds_allowin;
    logic        fs_allowin;
    logic        ds_valid;
    logic [31:0] ds_pc;
    logic [31:0] ds_inst;
    logic [1:0]  buf_count;

    int ntests = 0;
    int nfail  = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    if_inst_buffer #(.DEPTH(2), .RST_PC_VAL(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .fs_valid   (fs_valid),
        .fs_pc      (fs_pc),
        .fs_inst    (fs_inst),
        .br_flush   (br_flush),
        .ds_allowin (ds_allowin),
        .fs_allowin (fs_allowin),
        .ds_valid   (ds_valid),
        .ds_pc      (ds_pc),
        .ds_inst    (ds_inst),
        .buf_count  (buf_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, log what decode consumes, settle #1 after edge.
    task automatic cyc(input logic v, input logic [31:0] pc,
                       input logic fl, input logic da);
        fs_valid   = v;
        fs_pc      = pc;
        fs_inst    = ~pc;
        br_flush   = fl;
        ds_allowin = da;
        if (!rst && ds_valid && da) obs_q.push_back({ds_pc, ds_inst});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b1, BASE, 1'b0, 1'b1);
        cyc(1'b1, BASE + 32'h4, 1'b0, 1'b1);
        ntests++;
        if (ds_valid !== 1'b0) begin
            nfail++; $display("FAIL reset_valid: got %b want 0", ds_valid);
        end
        ntests++;
        if (ds_pc !== 32'h0 || ds_inst !== 32'h0) begin
            nfail++; $display("FAIL reset_data: got %h/%h want 0/0", ds_pc, ds_inst);
        end
        ntests++;
        if (buf_count !== 2'd0 || fs_allowin !== 1'b1) begin
            nfail++;
            $display("FAIL reset_cnt: got cnt %0d allow %b want 0/1", buf_count, fs_allowin);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [63:0] o, e;
        exp_q.delete(); obs_q.delete();
        ntests++;
        if (ds_valid !== 1'b0) begin
            nfail++; $display("FAIL stream_pre_valid: got %b want 0", ds_valid);
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] pc;
            pc = BASE + 32'(4 * i);
            exp_q.push_back({pc, ~pc});
            cyc(1'b1, pc, 1'b0, 1'b1);
            ntests++;
            if (ds_valid !== 1'b1 || ds_pc !== pc || ds_inst !== ~pc) begin
                nfail++;
                $display("FAIL stream_head%0d: got %b %h want 1 %h", i, ds_valid, ds_pc, pc);
            end
            ntests++;
            if (buf_count !== 2'd1 || fs_allowin !== 1'b1) begin
                nfail++;
                $display("FAIL stream_cnt%0d: got %0d/%b want 1/1", i, buf_count, fs_allowin);
            end
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        ntests++;
        if (buf_count !== 2'd0) begin
            nfail++; $display("FAIL stream_drain: got %0d want 0", buf_count);
        end
        ntests++;
        if (obs_q.size() != exp_q.size()) begin
            nfail++;
            $display("FAIL stream_sb_len: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            ntests++;
            if (o !== e) begin
                nfail++; $display("FAIL stream_sb: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] o, e;
        exp_q.delete(); obs_q.delete();
        exp_q.push_back({BASE, ~BASE});
        exp_q.push_back({BASE + 32'h4, ~(BASE + 32'h4)});
        exp_q.push_back({BASE + 32'h8, ~(BASE + 32'h8)});
        cyc(1'b1, BASE, 1'b0, 1'b0);
        ntests++;
        if (buf_count !== 2'd1 || fs_allowin !== 1'b1) begin
            nfail++; $display("FAIL bp_one: got %0d/%b want 1/1", buf_count, fs_allowin);
        end
        cyc(1'b1, BASE + 32'h4, 1'b0, 1'b0);
        ntests++;
        if (buf_count !== 2'd2 || fs_allowin !== 1'b0) begin
            nfail++; $display("FAIL bp_full: got %0d/%b want 2/0", buf_count, fs_allowin);
        end
        cyc(1'b1, BASE + 32'h8, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h8, 1'b0, 1'b0);
        ntests++;
        if (buf_count !== 2'd2 || ds_pc !== BASE) begin
            nfail++; $display("FAIL bp_hold: got %0d %h want 2 %h", buf_count, ds_pc, BASE);
        end
        cyc(1'b1, BASE + 32'h8, 1'b0, 1'b1);
        ntests++;
        if (buf_count !== 2'd1 || ds_pc !== BASE + 32'h4) begin
            nfail++;
            $display("FAIL bp_pop1: got %0d %h want 1 %h", buf_count, ds_pc, BASE + 32'h4);
        end
        cyc(1'b1, BASE + 32'h8, 1'b0, 1'b1);
        ntests++;
        if (buf_count !== 2'd1 || ds_pc !== BASE + 32'h8) begin
            nfail++;
            $display("FAIL bp_pop2: got %0d %h want 1 %h", buf_count, ds_pc, BASE + 32'h8);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        ntests++;
        if (obs_q.size() != 3 || buf_count !== 2'd0) begin
            nfail++;
            $display("FAIL bp_sb_len: got %0d cnt %0d want 3 cnt 0", obs_q.size(), buf_count);
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            ntests++;
            if (o !== e) begin
                nfail++; $display("FAIL bp_sb: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_branch();
        logic [63:0] o, e;
        exp_q.delete(); obs_q.delete();
        exp_q.push_back({BASE + 32'h10, ~(BASE + 32'h10)});
        exp_q.push_back({BASE + 32'h100, ~(BASE + 32'h100)});
        cyc(1'b1, BASE + 32'h10, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h14, 1'b1, 1'b1);
        ntests++;
        if (buf_count !== 2'd0 || ds_valid !== 1'b0) begin
            nfail++; $display("FAIL br_empty: got %0d/%b want 0/0", buf_count, ds_valid);
        end
        cyc(1'b1, BASE + 32'h100, 1'b0, 1'b1);
        ntests++;
        if (ds_valid !== 1'b1 || ds_pc !== BASE + 32'h100) begin
            nfail++;
            $display("FAIL br_target: got %b %h want 1 %h", ds_valid, ds_pc, BASE + 32'h100);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        ntests++;
        if (obs_q.size() != 2) begin
            nfail++; $display("FAIL br_sb_len: got %0d want 2", obs_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            ntests++;
            if (o !== e) begin
                nfail++; $display("FAIL br_sb: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_flush_full();
        logic [63:0] o, e;
        exp_q.delete(); obs_q.delete();
        exp_q.push_back({BASE + 32'h40, ~(BASE + 32'h40)});
        cyc(1'b1, BASE + 32'h40, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h44, 1'b0, 1'b0);
        ntests++;
        if (buf_count !== 2'd2 || fs_allowin !== 1'b0) begin
            nfail++; $display("FAIL ff_full: got %0d/%b want 2/0", buf_count, fs_allowin);
        end
        cyc(1'b1, BASE + 32'h48, 1'b1, 1'b1);
        ntests++;
        if (buf_count !== 2'd0 || fs_allowin !== 1'b1 || ds_valid !== 1'b0) begin
            nfail++;
            $display("FAIL ff_flush: got %0d/%b/%b want 0/1/0", buf_count, fs_allowin, ds_valid);
        end
        ntests++;
        if (obs_q.size() != 1) begin
            nfail++; $display("FAIL ff_sb_len: got %0d want 1", obs_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            ntests++;
            if (o !== e) begin
                nfail++; $display("FAIL ff_sb: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] o, e;
        int k, n;
        exp_q.delete(); obs_q.delete();
        k = 0; n = 0;
        while (k < 10 && n < 60) begin
            logic [31:0] pc;
            logic acc;
            pc  = BASE + 32'h200 + 32'(4 * k);
            acc = fs_allowin;
            cyc(1'b1, pc, 1'b0, n[0]);
            if (acc) begin
                exp_q.push_back({pc, ~pc});
                k++;
            end
            n++;
        end
        ntests++;
        if (k != 10) begin
            nfail++; $display("FAIL wrap_timeout: got %0d fetches want 10", k);
        end
        n = 0;
        while (ds_valid && n < 10) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        ntests++;
        if (ds_valid !== 1'b0 || obs_q.size() != 10) begin
            nfail++;
            $display("FAIL wrap_drain: got valid %b n %0d want 0 10", ds_valid, obs_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            ntests++;
            if (o !== e) begin
                nfail++; $display("FAIL wrap_sb: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        cyc(1'b1, BASE + 32'h80, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h84, 1'b0, 1'b0);
        ntests++;
        if (buf_count !== 2'd2) begin
            nfail++; $display("FAIL mr_pre: got %0d want 2", buf_count);
        end
        rst = 1'b1;
        cyc(1'b1, BASE + 32'h88, 1'b0, 1'b1);
        rst = 1'b0;
        ntests++;
        if (ds_valid !== 1'b0 || ds_inst !== 32'h0 || buf_count !== 2'd0) begin
            nfail++;
            $display("FAIL mr_clear: got %b %h %0d want 0 0 0", ds_valid, ds_inst, buf_count);
        end
        ntests++;
        if (ds_pc !== 32'h0 || fs_allowin !== 1'b1) begin
            nfail++; $display("FAIL mr_pc: got %h/%b want 0/1", ds_pc, fs_allowin);
        end
        cyc(1'b1, BASE + 32'h90, 1'b0, 1'b0);
        ntests++;
        if (buf_count !== 2'd1 || ds_pc !== BASE + 32'h90) begin
            nfail++;
            $display("FAIL mr_resume: got %0d %h want 1 %h", buf_count, ds_pc, BASE + 32'h90);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        fs_valid   = 1'b0;
        fs_pc      = 32'h0;
        fs_inst    = 32'h0;
        br_flush   = 1'b0;
        ds_allowin = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_flush_full();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/if_inst_buffer.md
Name: if_inst_buffer

Overview:
- Fetch-side decoupling buffer between the PC register / instruction SRAM and the decode stage.
- Each cycle it captures the fetch pair {PC, instruction}. The instruction returns from the synchronous-read SRAM one cycle after the address was issued, aligned with the registered PC.
- It holds captured pairs in a small FIFO so decode back-pressure never loses an instruction.
- It drops wrong-path fetches on a taken branch and returns an allow-in signal that holds the PC register.

Parameters:
- DEPTH, 2, number of buffered {pc, inst} entries; power of two, minimum 2.
- RST_PC_VAL, 32'h0, value driven on ds_pc while the buffer is empty or in reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset, sampled on posedge clk.
- fs_valid  input  1  fs_pc/fs_inst hold a real fetch this cycle; top level drives it as ~rst registered once.
- fs_pc  input  32  PC of the fetch whose data is on fs_inst (if_pc of the PC register).
- fs_inst  input  32  instruction SRAM read data for fs_pc.
- br_flush  input  1  taken branch resolved in decode this cycle (same net as pc_br_taken).
- ds_allowin  input  1  decode accepts the head entry this cycle.
- fs_allowin  output  1  buffer can accept a fetch this cycle; PC register and SRAM address hold when 0.
- ds_valid  output  1  head entry valid to decode.
- ds_pc  output  32  head entry PC.
- ds_inst  output  32  head entry instruction.
- buf_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular FIFO of 64-bit {pc, inst}. Head and tail pointers wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- fs_allowin = (buf_count != DEPTH). It is a function of registered state only, with no combinational path from ds_allowin.
- push = fs_valid & fs_allowin & ~br_flush.
- pop = ds_valid & ds_allowin.
- Count update:
  - count+1 on push only.
  - count-1 on pop only.
  - unchanged on push & pop.
- Push and pop in the same cycle:
  - At count 0: the entry is written, and ds_valid stays 0 that cycle. There is no bypass, so latency from fetch to decode is 1 cycle.
  - At count DEPTH: cannot occur, because fs_allowin=0.
- Outputs:
  - ds_valid = (count != 0).
  - ds_pc/ds_inst = head entry when valid.
  - When empty: ds_pc=RST_PC_VAL, ds_inst=32'h0.
- Flush:
  - When br_flush=1, on the next edge count=0, head=tail=0, and the pop is implied.
  - The fs pair present in the flush cycle is discarded, because it is the fall-through fetch.
  - The fetch in the following cycle carries the branch target and is pushed normally.
  - Flush takes priority over push and pop.
- Stall contract: while fs_allowin=0, the upstream side holds fs_pc and fs_inst stable. The SRAM re-reads the same address, and the buffer re-samples the pair when allow-in returns.
- Reset:
  - count=0, head=tail=0, ds_valid=0, ds_pc=RST_PC_VAL, ds_inst=0, fs_allowin=1.
  - Entry RAM contents are don't-care.
  - Reset asserted mid-stream discards all entries on that edge and has priority over flush, push and pop.
- While rst=1, fs_valid is ignored and nothing is pushed.
- Width rules: pointers are $clog2(DEPTH) bits and wrap naturally. The count is one bit wider and never exceeds DEPTH or goes below 0.

Test Plan:
- Reset then streaming:
  - Stimulus: release rst, fs_valid rises with fs_pc=1c000000, 1c000004, ..., ds_allowin=1 constant.
  - Required: ds_valid rises one cycle after the first push; ds_pc=1c000000 then +4 each cycle; buf_count stays 1; fs_allowin stays 1.
- Back-pressure fill:
  - Stimulus: ds_allowin=0 for 4 cycles while fetching 1c000000..
  - Required: buf_count goes 1 then 2; fs_allowin drops to 0 after 2 pushes.
  - Required on ds_allowin=1: entries drain in order 1c000000, 1c000004, then 1c000008 is accepted; no entry is lost or duplicated.
- Taken branch:
  - Stimulus: head=1c000010 popped with br_flush=1 while fs_pc=1c000014; next cycle fs_pc=1c000100.
  - Required: 1c000014 never appears on ds_pc; next ds_pc=1c000100; buf_count is 0 for one cycle.
- Flush while full:
  - Stimulus: buffer at count=2, ds_allowin=1, br_flush=1.
  - Required: count=0 next cycle; fs_allowin=1 next cycle.
- Wrap-around:
  - Stimulus: 10 fetches with an alternating ds_allowin pattern.
  - Required: pointers wrap past DEPTH-1; output PC order is identical to input order.
- Mid-operation reset:
  - Stimulus: rst=1 for one cycle at count=2.
  - Required: ds_valid=0, ds_inst=0, buf_count=0 on the next edge; fs_valid ignored while rst=1.
